uart_8n1_receiver: RTL and testbench

UART_8N1_RECEIVER -- requirements
Module: uart_8n1_receiver

---
 rtl/uart_8n1_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_8n1_receiver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_8n1_receiver.sv
// rtl/uart_8n1_receiver.sv - 8N1 UART receiver, 16x oversampled with 3-sample majority vote
module uart_8n1_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_baud_16x,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  output logic       recv_frame_err,
  output logic       recv_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_tick;
  logic [2:0]             r_index;
  logic [7:0]             r_shift;
  logic                   r_s7;
  logic                   r_s8;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_busy;

  logic                   w_rx_s;
  logic                   w_vote;

  // Chain presets to idle-high so leaving reset with rx high cannot look like a start bit.
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_vote = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tick      <= 4'd0;
      r_index     <= 3'd0;
      r_shift     <= 8'h00;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_tick == 4'd7) begin
        r_s7 <= w_rx_s;
      end
      if (r_tick == 4'd8) begin
        r_s8 <= w_rx_s;
      end

      case (r_state)
        S_IDLE: begin
          r_tick  <= 4'd0;
          r_index <= 3'd0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd9 && w_vote) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tick == 4'd15) begin
            r_state <= S_DATA;
            r_index <= 3'd0;
          end
        end

        S_DATA: begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd9) begin
            r_shift <= {w_vote, r_shift[7:1]};
          end
          if (r_tick == 4'd15) begin
            r_index <= r_index + 3'd1;
            if (r_index == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end

        // Leaving at tick 9 gives the next start bit slack to arrive early.
        S_STOP: begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd9) begin
            if (w_vote) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end
        end

        S_WAIT_HIGH: begin
          r_tick <= 4'd0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tick  <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign recv_data      = r_data;
  assign recv_valid     = r_valid;
  assign recv_frame_err = r_frame_err;
  assign recv_busy      = r_busy;

endmodule

// File: tb/tb_uart_8n1_receiver.sv
// tb/tb_uart_8n1_receiver.sv - scoreboard bench for uart_8n1_receiver
module tb_uart_8n1_receiver;

  localparam int SYNC = 2;
  localparam int VALID_LAT = SYNC + 1 + 154;

  logic       clk_baud_16x = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       recv_frame_err;
  logic       recv_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         t_drive  = 0;
  bit         lat_armed = 1'b0;
  bit         have_prev = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] last_good = 8'h00;
  logic [8:0] exp_q[$];

  uart_8n1_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk_baud_16x  (clk_baud_16x),
    .reset_n       (reset_n),
    .rx            (rx),
    .recv_data     (recv_data),
    .recv_valid    (recv_valid),
    .recv_frame_err(recv_frame_err),
    .recv_busy     (recv_busy)
  );

  always #5 clk_baud_16x = ~clk_baud_16x;

  always @(posedge clk_baud_16x) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of the expected queue.
  always @(negedge clk_baud_16x) begin
    logic [8:0] e;
    if (reset_n) begin
      if (recv_valid || recv_frame_err) begin
        check_eq("pulse_exclusive", {31'd0, recv_valid & recv_frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("pulse_kind", {31'd0, recv_frame_err}, {31'd0, e[8]});
          check_eq("recv_data", {24'd0, recv_data}, {24'd0, e[7:0]});
        end
      end
      if (lat_armed && recv_valid) begin
        check_eq("valid_latency", cyc - t_drive, VALID_LAT);
        lat_armed = 1'b0;
      end
      if (have_prev && !recv_valid) begin
        check_eq("data_hold", {24'd0, recv_data}, {24'd0, prev_data});
      end
      prev_data = recv_data;
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  task automatic drive_slot(input logic v);
    @(posedge clk_baud_16x);
    #1 rx = v;
  endtask

  task automatic drive_bit(input logic v, input int glitch_slot);
    for (int s = 0; s < 16; s++) drive_slot((s == glitch_slot) ? ~v : v);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_slots,
                            input int glitch_bit, input int glitch_slot, input bit arm);
    if (stop_v) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    drive_slot(1'b0);
    if (arm) begin
      t_drive   = cyc;
      lat_armed = 1'b1;
    end
    for (int s = 1; s < 16; s++) drive_slot(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == glitch_bit) ? glitch_slot : -1);
    for (int s = 0; s < stop_slots; s++) drive_slot(stop_v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_slot(1'b1);
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] pb;

    rx      = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("reset_data",  {24'd0, recv_data}, 32'h00);
    check_eq("reset_valid", {31'd0, recv_valid}, 32'd0);
    check_eq("reset_ferr",  {31'd0, recv_frame_err}, 32'd0);
    check_eq("reset_busy",  {31'd0, recv_busy}, 32'd0);
    repeat (3) @(posedge clk_baud_16x);
    #1 reset_n = 1'b1;

    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_slot(1'b1);
      @(negedge clk_baud_16x);
      if (recv_busy) busy_cnt++;
    end
    check_eq("no_false_start_after_reset", busy_cnt, 32'd0);

    send_frame(8'h55, 1'b1, 16, -1, -1, 1'b1);
    idle_cycles(10);

    send_frame(8'hA5, 1'b1, 12, -1, -1, 1'b0);
    send_frame(8'h3C, 1'b1, 16, -1, -1, 1'b0);
    idle_cycles(10);

    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      drive_slot((i < 5) ? 1'b0 : 1'b1);
      @(negedge clk_baud_16x);
      if (recv_busy) busy_cnt++;
    end
    check_eq("false_start_busy_cycles", busy_cnt, 32'd10);

    send_frame(8'hF0, 1'b1, 16, 2, 9, 1'b0);
    idle_cycles(10);

    send_frame(8'h81, 1'b0, 16, -1, -1, 1'b0);
    for (int i = 0; i < 640; i++) begin
      drive_slot(1'b0);
      if (i % 64 == 0) begin
        @(negedge clk_baud_16x);
        check_eq("break_busy", {31'd0, recv_busy}, 32'd1);
      end
    end
    idle_cycles(5);
    @(negedge clk_baud_16x);
    check_eq("break_released_busy", {31'd0, recv_busy}, 32'd0);
    check_eq("break_data_unchanged", {24'd0, recv_data}, 32'hF0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      drive_slot(1'b1);
      @(negedge clk_baud_16x);
      if (recv_busy) busy_cnt++;
    end
    check_eq("no_start_after_break", busy_cnt, 32'd0);

    pb = 8'hF5;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(pb[i], -1);
    for (int s = 0; s < 8; s++) drive_slot(pb[4]);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midframe_reset_data",  {24'd0, recv_data}, 32'h00);
    check_eq("midframe_reset_valid", {31'd0, recv_valid}, 32'd0);
    check_eq("midframe_reset_ferr",  {31'd0, recv_frame_err}, 32'd0);
    check_eq("midframe_reset_busy",  {31'd0, recv_busy}, 32'd0);
    last_good = 8'h00;
    repeat (3) @(posedge clk_baud_16x);
    #1 reset_n = 1'b1;
    for (int s = 0; s < 8; s++) drive_slot(pb[4]);
    for (int i = 5; i < 8; i++) drive_bit(pb[i], -1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_slot(1'b1);
      @(negedge clk_baud_16x);
      if (recv_busy) busy_cnt++;
    end
    check_eq("post_reset_idle", busy_cnt, 32'd0);
    check_eq("post_reset_data", {24'd0, recv_data}, 32'h00);

    send_frame(8'h42, 1'b1, 16, -1, -1, 1'b0);
    idle_cycles(40);
    check_eq("final_data", {24'd0, recv_data}, 32'h42);
    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
